// File: rtl/control_unit_pkg.sv
// Shared ISA definitions for the DRFA control unit: instruction fields, opcodes,
// FSM states, ALU-op and data-source encodings.
package control_unit_pkg;

    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 11;
    localparam int RX_MSB     = 10;
    localparam int RX_LSB     = 8;
    localparam int RY_MSB     = 7;
    localparam int RY_LSB     = 5;
    localparam int IMM_MSB    = 7;
    localparam int IMM_LSB    = 0;

    localparam logic [4:0] OP_NOP    = 5'b00000;
    localparam logic [4:0] OP_MOV    = 5'b00001;
    localparam logic [4:0] OP_LDI    = 5'b00010;
    localparam logic [4:0] OP_ADD    = 5'b00011;
    localparam logic [4:0] OP_SUB    = 5'b00100;
    localparam logic [4:0] OP_AND    = 5'b00101;
    localparam logic [4:0] OP_OR     = 5'b00110;
    localparam logic [4:0] OP_CMP    = 5'b00111;
    localparam logic [4:0] OP_JMP    = 5'b01000;
    localparam logic [4:0] OP_JZ     = 5'b01001;
    localparam logic [4:0] OP_JC     = 5'b01010;
    localparam logic [4:0] OP_MOVIND = 5'b01011;
    localparam logic [4:0] OP_HALT   = 5'b11111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam logic [1:0] DATA_SRC_IMM = 2'b00;
    localparam logic [1:0] DATA_SRC_ALU = 2'b01;
    localparam logic [1:0] DATA_SRC_BUS = 2'b10;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_HALT
    } state_t;

    typedef enum logic [3:0] {
        CLS_NOP,
        CLS_MOV,
        CLS_MOVIND,
        CLS_LDI,
        CLS_ALU,
        CLS_CMP,
        CLS_JMP,
        CLS_JZ,
        CLS_JC,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_t;

    function automatic logic [4:0] opcode_of(input logic [15:0] ir);
        return ir[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/control_unit_instruction_decoder.sv
// Combinational opcode decoder: classifies the opcode and derives write/flag/jump
// attributes plus ALU op and data source. MOVIND is legal only with CU_INDIRECT_EN.
module instruction_decoder
    import control_unit_pkg::*;
(
    input  logic [4:0] opcode,
    output op_class_t  op_class,
    output logic       legal,
    output logic       writes_rx,
    output logic       updates_flags,
    output logic       is_jump,
    output logic [1:0] alu_op,
    output logic [1:0] data_src
);

    always_comb begin
        op_class      = CLS_ILLEGAL;
        legal         = 1'b1;
        writes_rx     = 1'b0;
        updates_flags = 1'b0;
        is_jump       = 1'b0;
        alu_op        = ALU_ADD;
        data_src      = DATA_SRC_IMM;
        case (opcode)
            OP_NOP: op_class = CLS_NOP;
            OP_MOV: begin
                op_class  = CLS_MOV;
                writes_rx = 1'b1;
                data_src  = DATA_SRC_BUS;
            end
            OP_LDI: begin
                op_class  = CLS_LDI;
                writes_rx = 1'b1;
                data_src  = DATA_SRC_IMM;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                op_class      = CLS_ALU;
                writes_rx     = 1'b1;
                updates_flags = 1'b1;
                data_src      = DATA_SRC_ALU;
                // ADD..OR are consecutive opcodes mapping onto ALU codes 00..11
                alu_op        = opcode[1:0] - 2'b11;
            end
            OP_CMP: begin
                op_class      = CLS_CMP;
                updates_flags = 1'b1;
                alu_op        = ALU_SUB;
            end
            OP_JMP: begin
                op_class = CLS_JMP;
                is_jump  = 1'b1;
            end
            OP_JZ: begin
                op_class = CLS_JZ;
                is_jump  = 1'b1;
            end
            OP_JC: begin
                op_class = CLS_JC;
                is_jump  = 1'b1;
            end
`ifdef CU_INDIRECT_EN
            OP_MOVIND: begin
                op_class  = CLS_MOVIND;
                writes_rx = 1'b1;
                data_src  = DATA_SRC_BUS;
            end
`endif
            OP_HALT: op_class = CLS_HALT;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// DRFA instruction sequencer: FETCH/DECODE/EXEC/WB FSM, PC, IR and Z/C flags.
// Optional macro CU_INDIRECT_EN enables the MOVIND instruction.
module control_unit
    import control_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_instr,
    input  logic        in_alu_zero,
    input  logic        in_alu_carry,
    output logic [7:0]  out_pc,
    output logic        out_rb_write_en,
    output logic        out_rb_read_en,
    output logic [2:0]  out_rb_rx_selector,
    output logic [2:0]  out_rb_ry_selector,
    output logic        out_rb_indirect_mode_en,
    output logic [1:0]  out_alu_op,
    output logic [1:0]  out_data_src,
    output logic [7:0]  out_imm,
    output logic        out_zero_flag,
    output logic        out_carry_flag,
    output logic        out_halted,
    output logic        out_illegal
);

    state_t      state_reg, state_next;
    logic [7:0]  pc_reg, pc_next;
    logic [15:0] ir_reg, ir_next;
    logic        zero_reg, zero_next;
    logic        carry_reg, carry_next;
    logic        illegal_reg, illegal_next;

    logic [4:0]  opcode;
    op_class_t   dec_class;
    logic        dec_legal;
    logic        dec_writes_rx;
    logic        dec_updates_flags;
    logic        dec_is_jump;
    logic [1:0]  dec_alu_op;
    logic [1:0]  dec_data_src;
    logic        jump_taken;
    logic        reads_reg;

    assign opcode = opcode_of(ir_reg);

    instruction_decoder u_decoder (
        .opcode        (opcode),
        .op_class      (dec_class),
        .legal         (dec_legal),
        .writes_rx     (dec_writes_rx),
        .updates_flags (dec_updates_flags),
        .is_jump       (dec_is_jump),
        .alu_op        (dec_alu_op),
        .data_src      (dec_data_src)
    );

    always_comb begin
        jump_taken = 1'b0;
        if (dec_is_jump) begin
            case (dec_class)
                CLS_JMP: jump_taken = 1'b1;
                CLS_JZ:  jump_taken = zero_reg;
                CLS_JC:  jump_taken = carry_reg;
                default: jump_taken = 1'b0;
            endcase
        end
    end

    assign reads_reg = (dec_class == CLS_MOV) || (dec_class == CLS_MOVIND);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_FETCH;
            pc_reg      <= 8'h00;
            ir_reg      <= 16'h0000;
            zero_reg    <= 1'b0;
            carry_reg   <= 1'b0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            ir_reg      <= ir_next;
            zero_reg    <= zero_next;
            carry_reg   <= carry_next;
            illegal_reg <= illegal_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        ir_next      = ir_reg;
        zero_next    = zero_reg;
        carry_next   = carry_reg;
        illegal_next = illegal_reg;

        out_rb_write_en         = 1'b0;
        out_rb_read_en          = 1'b0;
        out_rb_rx_selector      = 3'd0;
        out_rb_ry_selector      = 3'd0;
        out_rb_indirect_mode_en = 1'b0;
        out_alu_op              = ALU_ADD;
        out_data_src            = DATA_SRC_IMM;

        case (state_reg)
            ST_FETCH: begin
                ir_next    = in_instr;
                pc_next    = pc_reg + 8'd1;
                state_next = ST_DECODE;
            end
            ST_DECODE: begin
                out_rb_rx_selector = ir_reg[RX_MSB:RX_LSB];
                out_rb_ry_selector = ir_reg[RY_MSB:RY_LSB];
                if (!dec_legal) begin
                    illegal_next = 1'b1;
                    state_next   = ST_HALT;
                end else if (dec_class == CLS_HALT) begin
                    state_next = ST_HALT;
                end else begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC, ST_WB: begin
                out_rb_rx_selector = ir_reg[RX_MSB:RX_LSB];
                out_rb_ry_selector = ir_reg[RY_MSB:RY_LSB];
                out_rb_read_en     = reads_reg;
`ifdef CU_INDIRECT_EN
                out_rb_indirect_mode_en = (dec_class == CLS_MOVIND);
`endif
                out_alu_op = dec_alu_op;
                if (dec_writes_rx) begin
                    out_data_src = dec_data_src;
                end
                if (state_reg == ST_WB) begin
                    out_rb_write_en = 1'b1;
                    state_next      = ST_FETCH;
                end else begin
                    if (dec_updates_flags) begin
                        zero_next  = in_alu_zero;
                        // logical ops never produce a carry
                        carry_next = (dec_alu_op == ALU_AND || dec_alu_op == ALU_OR)
                                     ? 1'b0 : in_alu_carry;
                    end
                    if (jump_taken) begin
                        pc_next = ir_reg[IMM_MSB:IMM_LSB];
                    end
                    state_next = dec_writes_rx ? ST_WB : ST_FETCH;
                end
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_FETCH;
        endcase
    end

    assign out_pc         = pc_reg;
    assign out_imm        = ir_reg[IMM_MSB:IMM_LSB];
    assign out_zero_flag  = zero_reg;
    assign out_carry_flag = carry_reg;
    assign out_halted     = (state_reg == ST_HALT);
    assign out_illegal    = illegal_reg;

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit; expectations hand-derived per instruction.
// MOVIND checks follow CU_INDIRECT_EN.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] in_instr;
    logic        in_alu_zero = 1'b0;
    logic        in_alu_carry = 1'b0;
    logic [7:0]  out_pc;
    logic        out_rb_write_en, out_rb_read_en, out_rb_indirect_mode_en;
    logic [2:0]  out_rb_rx_selector, out_rb_ry_selector;
    logic [1:0]  out_alu_op, out_data_src;
    logic [7:0]  out_imm;
    logic        out_zero_flag, out_carry_flag, out_halted, out_illegal;

    logic [15:0] rom [256];
    int vectors = 0;
    int miscompares = 0;

    assign in_instr = rom[out_pc];

    always #5 clk = ~clk;

    control_unit dut (
        .clk                     (clk),
        .rst                     (rst),
        .in_instr                (in_instr),
        .in_alu_zero             (in_alu_zero),
        .in_alu_carry            (in_alu_carry),
        .out_pc                  (out_pc),
        .out_rb_write_en         (out_rb_write_en),
        .out_rb_read_en          (out_rb_read_en),
        .out_rb_rx_selector      (out_rb_rx_selector),
        .out_rb_ry_selector      (out_rb_ry_selector),
        .out_rb_indirect_mode_en (out_rb_indirect_mode_en),
        .out_alu_op              (out_alu_op),
        .out_data_src            (out_data_src),
        .out_imm                 (out_imm),
        .out_zero_flag           (out_zero_flag),
        .out_carry_flag          (out_carry_flag),
        .out_halted              (out_halted),
        .out_illegal             (out_illegal)
    );

    function automatic logic [15:0] enc(input logic [4:0] op, input logic [2:0] rx,
                                        input logic [7:0] low);
        return {op, rx, low};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_rom();
        rom[0] = enc(5'b00010, 3'd4, 8'hAA);
        do_reset();
        vectors++; if (out_pc !== 8'h00) begin miscompares++; $display("FAIL reset_pc got %h want 00", out_pc); end
        vectors++; if ({out_rb_write_en, out_rb_read_en, out_rb_indirect_mode_en} !== 3'b000) begin
            miscompares++; $display("FAIL reset_enables got %b want 000", {out_rb_write_en, out_rb_read_en, out_rb_indirect_mode_en}); end
        vectors++; if ({out_rb_rx_selector, out_rb_ry_selector, out_alu_op, out_data_src, out_imm} !== 18'h0) begin
            miscompares++; $display("FAIL reset_fields got %h want 0", {out_rb_rx_selector, out_rb_ry_selector, out_alu_op, out_data_src, out_imm}); end
        vectors++; if ({out_zero_flag, out_carry_flag, out_halted, out_illegal} !== 4'b0000) begin
            miscompares++; $display("FAIL reset_status got %b want 0000", {out_zero_flag, out_carry_flag, out_halted, out_illegal}); end
        $display("reset: pc=%h halted=%b illegal=%b", out_pc, out_halted, out_illegal);
    endtask

    // Continues from test_reset: LDI R4,AA sits at address 0.
    task automatic test_ldi();
        tick(); // DECODE
        vectors++; if (out_pc !== 8'h01) begin miscompares++; $display("FAIL ldi_pc_after_fetch got %h want 01", out_pc); end
        vectors++; if (out_rb_write_en !== 1'b0) begin miscompares++; $display("FAIL ldi_we_decode got %b want 0", out_rb_write_en); end
        tick(); // EXEC
        vectors++; if (out_rb_write_en !== 1'b0) begin miscompares++; $display("FAIL ldi_we_exec got %b want 0", out_rb_write_en); end
        tick(); // WB
        vectors++; if (out_rb_write_en !== 1'b1) begin miscompares++; $display("FAIL ldi_we_wb got %b want 1", out_rb_write_en); end
        vectors++; if (out_rb_rx_selector !== 3'd4) begin miscompares++; $display("FAIL ldi_rx got %0d want 4", out_rb_rx_selector); end
        vectors++; if (out_data_src !== 2'b00) begin miscompares++; $display("FAIL ldi_data_src got %b want 00", out_data_src); end
        vectors++; if (out_imm !== 8'hAA) begin miscompares++; $display("FAIL ldi_imm got %h want aa", out_imm); end
        tick(); // FETCH of next
        vectors++; if (out_rb_write_en !== 1'b0 || out_pc !== 8'h01) begin
            miscompares++; $display("FAIL ldi_after got we=%b pc=%h want we=0 pc=01", out_rb_write_en, out_pc); end
        $display("LDI R4,AA: pc=%h", out_pc);
    endtask

    task automatic test_alu_flags();
        clear_rom();
        rom[0] = enc(5'b00011, 3'd1, {3'd2, 5'b0}); // ADD R1,R2
        rom[1] = enc(5'b00101, 3'd1, {3'd2, 5'b0}); // AND R1,R2
        in_alu_zero = 1'b1; in_alu_carry = 1'b1;
        do_reset();
        tick(); tick(); // EXEC of ADD
        vectors++; if (out_alu_op !== 2'b00 || out_rb_write_en !== 1'b0) begin
            miscompares++; $display("FAIL add_exec got op=%b we=%b want op=00 we=0", out_alu_op, out_rb_write_en); end
        vectors++; if (out_rb_rx_selector !== 3'd1 || out_rb_ry_selector !== 3'd2) begin
            miscompares++; $display("FAIL add_sel got rx=%0d ry=%0d want 1 2", out_rb_rx_selector, out_rb_ry_selector); end
        vectors++; if ({out_zero_flag, out_carry_flag} !== 2'b00) begin
            miscompares++; $display("FAIL add_flags_exec got %b want 00", {out_zero_flag, out_carry_flag}); end
        tick(); // WB
        vectors++; if ({out_zero_flag, out_carry_flag} !== 2'b11) begin
            miscompares++; $display("FAIL add_flags got %b want 11", {out_zero_flag, out_carry_flag}); end
        vectors++; if (out_rb_write_en !== 1'b1 || out_data_src !== 2'b01) begin
            miscompares++; $display("FAIL add_wb got we=%b src=%b want 1 01", out_rb_write_en, out_data_src); end
        $display("ADD R1,R2: z=%b c=%b", out_zero_flag, out_carry_flag);
        in_alu_zero = 1'b0; in_alu_carry = 1'b1;
        tick(); tick(); tick(); // FETCH, DECODE, EXEC of AND
        vectors++; if (out_alu_op !== 2'b10) begin miscompares++; $display("FAIL and_op got %b want 10", out_alu_op); end
        tick(); // WB
        vectors++; if ({out_zero_flag, out_carry_flag} !== 2'b00) begin
            miscompares++; $display("FAIL and_flags got %b want 00", {out_zero_flag, out_carry_flag}); end
        vectors++; if (out_rb_write_en !== 1'b1) begin miscompares++; $display("FAIL and_we got %b want 1", out_rb_write_en); end
        $display("AND R1,R2: z=%b c=%b", out_zero_flag, out_carry_flag);
    endtask

    task automatic run_jz(input logic z_in, input logic [7:0] want_pc);
        int we_seen;
        clear_rom();
        rom[0] = enc(5'b00111, 3'd0, {3'd1, 5'b0}); // CMP R0,R1
        rom[1] = enc(5'b01001, 3'd0, 8'h10);        // JZ 10
        in_alu_zero = z_in; in_alu_carry = 1'b0;
        do_reset();
        we_seen = 0;
        for (int i = 0; i < 6; i++) begin // CMP (3) + JZ (3)
            tick();
            if (out_rb_write_en) we_seen++;
            if (i == 2) begin
                vectors++; if (out_zero_flag !== z_in || out_pc !== 8'h01) begin
                    miscompares++; $display("FAIL cmp_done got z=%b pc=%h want z=%b pc=01", out_zero_flag, out_pc, z_in); end
            end
        end
        vectors++; if (out_pc !== want_pc) begin miscompares++; $display("FAIL jz_pc got %h want %h", out_pc, want_pc); end
        vectors++; if (we_seen !== 0) begin miscompares++; $display("FAIL jz_no_write got %0d want 0", we_seen); end
        tick(); // next FETCH completes
        vectors++; if (out_pc !== want_pc + 8'd1) begin
            miscompares++; $display("FAIL jz_refetch got %h want %h", out_pc, want_pc + 8'd1); end
        $display("CMP;JZ 10 with z=%b: pc=%h", z_in, out_pc);
    endtask

    task automatic test_jumps();
        run_jz(1'b1, 8'h10);
        run_jz(1'b0, 8'h02);
    endtask

    task automatic test_movind();
        clear_rom();
        rom[0] = enc(5'b01011, 3'd0, {3'd3, 5'b0});
        do_reset();
        tick(); // DECODE
        tick();
`ifdef CU_INDIRECT_EN
        vectors++; if ({out_rb_read_en, out_rb_indirect_mode_en, out_rb_write_en} !== 3'b110) begin
            miscompares++; $display("FAIL movind_exec got %b want 110", {out_rb_read_en, out_rb_indirect_mode_en, out_rb_write_en}); end
        tick();
        vectors++; if ({out_rb_read_en, out_rb_indirect_mode_en, out_rb_write_en} !== 3'b111) begin
            miscompares++; $display("FAIL movind_wb got %b want 111", {out_rb_read_en, out_rb_indirect_mode_en, out_rb_write_en}); end
        vectors++; if (out_data_src !== 2'b10 || out_rb_ry_selector !== 3'd3) begin
            miscompares++; $display("FAIL movind_src got src=%b ry=%0d want 10 3", out_data_src, out_rb_ry_selector); end
`else
        vectors++; if ({out_halted, out_illegal} !== 2'b11) begin
            miscompares++; $display("FAIL movind_illegal got %b want 11", {out_halted, out_illegal}); end
        vectors++; if ({out_rb_read_en, out_rb_indirect_mode_en, out_rb_write_en} !== 3'b000) begin
            miscompares++; $display("FAIL movind_enables got %b want 000", {out_rb_read_en, out_rb_indirect_mode_en, out_rb_write_en}); end
`endif
        $display("MOVIND R0,[R3]: halted=%b illegal=%b", out_halted, out_illegal);
    endtask

    task automatic test_wrap();
        clear_rom();
        rom[0]     = enc(5'b01000, 3'd0, 8'hFF); // JMP FF
        rom[8'hFF] = 16'h0000;                   // NOP
        do_reset();
        tick(); tick(); tick(); // JMP
        vectors++; if (out_pc !== 8'hFF) begin miscompares++; $display("FAIL jmp_ff got %h want ff", out_pc); end
        tick();
        vectors++; if (out_pc !== 8'h00) begin miscompares++; $display("FAIL pc_wrap got %h want 00", out_pc); end
        $display("NOP at FF: pc=%h", out_pc);
        rom[8'hFF] = enc(5'b01000, 3'd0, 8'h20); // JMP 20 at wrap point
        do_reset();
        for (int i = 0; i < 6; i++) tick();
        vectors++; if (out_pc !== 8'h20) begin miscompares++; $display("FAIL jmp_at_wrap got %h want 20", out_pc); end
        $display("JMP 20 at FF: pc=%h", out_pc);
    endtask

    task automatic test_halt();
        clear_rom();
        rom[0] = enc(5'b10000, 3'd0, 8'h00);
        do_reset();
        tick(); // DECODE
        vectors++; if ({out_halted, out_illegal} !== 2'b00) begin
            miscompares++; $display("FAIL illegal_decode got %b want 00", {out_halted, out_illegal}); end
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++; if (out_pc !== 8'h01 || {out_halted, out_illegal, out_rb_write_en} !== 3'b110) begin
                miscompares++; $display("FAIL illegal_hold[%0d] got pc=%h h/i/we=%b want 01 110", i, out_pc, {out_halted, out_illegal, out_rb_write_en}); end
        end
        $display("opcode 10000: pc=%h halted=%b illegal=%b", out_pc, out_halted, out_illegal);
        rom[0] = 16'hF800; // HALT
        do_reset();
        tick(); tick();
        vectors++; if ({out_halted, out_illegal} !== 2'b10) begin
            miscompares++; $display("FAIL halt_op got %b want 10", {out_halted, out_illegal}); end
        $display("HALT: halted=%b illegal=%b", out_halted, out_illegal);
    endtask

    task automatic test_reset_mid();
        clear_rom();
        rom[0] = enc(5'b00011, 3'd1, {3'd2, 5'b0});
        rom[1] = enc(5'b00011, 3'd1, {3'd2, 5'b0});
        in_alu_zero = 1'b1; in_alu_carry = 1'b1;
        do_reset();
        tick(); tick(); tick(); // WB
        vectors++; if (out_rb_write_en !== 1'b1) begin miscompares++; $display("FAIL mid_wb got %b want 1", out_rb_write_en); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++; if (out_rb_write_en !== 1'b0) begin miscompares++; $display("FAIL mid_no_write got %b want 0", out_rb_write_en); end
        vectors++; if (out_pc !== 8'h00 || {out_zero_flag, out_carry_flag} !== 2'b00) begin
            miscompares++; $display("FAIL mid_state got pc=%h zc=%b want 00 00", out_pc, {out_zero_flag, out_carry_flag}); end
        tick(); // FETCH completes
        vectors++; if (out_pc !== 8'h01 || out_rb_write_en !== 1'b0) begin
            miscompares++; $display("FAIL mid_refetch got pc=%h we=%b want 01 0", out_pc, out_rb_write_en); end
        $display("reset during WB: pc=%h", out_pc);
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_alu_flags();
        test_jumps();
        test_movind();
        test_wrap();
        test_halt();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Instruction sequencer for the 8-bit DRFA core, sitting directly upstream of `register_bank`. Fetches 16-bit instructions from a combinational program ROM, decodes them and drives every `register_bank` control input (`write_en`, `read_en`, Rx/Ry selectors, indirect mode), the ALU op select, and the datapath source mux. It holds the program counter and the Z/C flag register, and implements conditional jumps.

## Interface
- No parameters. Widths are fixed by the ISA in `control_unit_pkg`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_instr` in 16: ROM word at `out_pc`, combinational, valid in the same cycle.
- `in_alu_zero` in 1: ALU zero result.
- `in_alu_carry` in 1: ALU carry/borrow result.
- `out_pc` out 8: program counter.
- `out_rb_write_en` out 1: to `register_bank.write_en`.
- `out_rb_read_en` out 1: to `register_bank.read_en`.
- `out_rb_rx_selector` out 3: to `register_bank.in_rx_selector`.
- `out_rb_ry_selector` out 3: to `register_bank.in_ry_selector`.
- `out_rb_indirect_mode_en` out 1: to `register_bank.in_indirect_mode_en`.
- `out_alu_op` out 2: 00 ADD, 01 SUB, 10 AND, 11 OR.
- `out_data_src` out 2: register-bank `in_data` mux. 00 = `out_imm`, 01 = ALU result, 10 = `out_bus_data`.
- `out_imm` out 8: `IR[7:0]`.
- `out_zero_flag`, `out_carry_flag` out 1: flag register.
- `out_halted` out 1: core stopped.
- `out_illegal` out 1: sticky; set when an illegal opcode was fetched.

## Operation
- Instruction fields: opcode `IR[15:11]`, Rx `IR[10:8]`, Ry `IR[7:5]`, imm8 `IR[7:0]`.
- Opcodes:
  - 00000 NOP
  - 00001 MOV Rx,Ry
  - 00010 LDI Rx,imm
  - 00011 ADD Rx,Ry
  - 00100 SUB
  - 00101 AND
  - 00110 OR
  - 00111 CMP (SUB, flags only)
  - 01000 JMP imm
  - 01001 JZ imm
  - 01010 JC imm
  - 01011 MOVIND Rx,[Ry]
  - 11111 HALT
  - All other opcodes are illegal.
- FSM states: FETCH → DECODE → EXEC → WB → FETCH. HALT is absorbing until `rst`.
- FETCH: IR ← `in_instr`; PC ← PC+1 (mod 256; 8'hFF wraps to 8'h00).
- DECODE: selectors driven from IR. Selectors are held unchanged through EXEC and WB. Illegal opcode or HALT → HALT state next cycle.
- EXEC:
  - MOV: `read_en`=1.
  - MOVIND: `read_en`=1 and `indirect_mode_en`=1.
  - ALU ops: `out_alu_op` valid. Z/C latched at the end of EXEC for ADD, SUB, AND, OR, CMP only. AND and OR clear C.
  - JMP, taken JZ, taken JC: PC ← imm at the end of EXEC, then → FETCH (skip WB).
  - Untaken jumps, NOP, CMP: → FETCH.
- WB: `write_en`=1; `read_en` and `indirect_mode_en` held as in EXEC.
  - LDI: `data_src`=00.
  - ALU ops: `data_src`=01.
  - MOV/MOVIND: `data_src`=10.
- All outputs are Moore-decoded from state and IR. Enables are 0 in FETCH, DECODE and HALT.

## Timing
- Cycles per instruction:
  - 4: MOV, MOVIND, LDI, ADD/SUB/AND/OR.
  - 3: NOP, CMP, all jumps.
- `write_en` is high for exactly one cycle per writing instruction. It is never high in the same cycle as a flag update.
- Reset values: PC=0, IR=0, state=FETCH, flags=0, `halted`=0, `illegal`=0, all enables 0, selectors 0, `alu_op`=0, `data_src`=0.
- Reset mid-instruction aborts the instruction. No write occurs in the cycle after the `rst` edge.
- HALT: `out_halted`=1 from the cycle after DECODE. PC frozen. `out_illegal` is set in the same cycle only when the opcode was illegal.
- A jump in EXEC at PC wrap loads imm; the wrap value is discarded.

## Configuration
- `CU_INDIRECT_EN` defined: MOVIND is decoded as specified above.
- `CU_INDIRECT_EN` undefined: opcode 01011 is illegal (→ HALT, `out_illegal`=1). `out_rb_indirect_mode_en` is tied to 0.

## Structure
- `control_unit_pkg`: opcode localparams, state enum, `alu_op` and `data_src` encodings, field bit positions.
- One sub-module, `instruction_decoder` (combinational): IR → opcode class, legality, `writes_rx`, `updates_flags`, `is_jump`, `alu_op`, `data_src`. The FSM, PC and flags stay in `control_unit`.

## Test plan
- Reset, then LDI R4,8'hAA at PC 0 → WB cycle 4: `write_en`=1, rx=4, `data_src`=00, `imm`=8'hAA. PC=1 after FETCH.
- ADD R1,R2 with `in_alu_zero`=1, `in_alu_carry`=1 → Z=C=1 after EXEC. `write_en` only in WB. Following AND clears C.
- JZ 8'h10 with Z=1 → PC=8'h10, 3 cycles, no `write_en`. With Z=0 → PC=next sequential address.
- MOVIND R0,[R3] → EXEC/WB: `read_en`=1, `indirect_mode_en`=1, `data_src`=10. Without `CU_INDIRECT_EN` → `halted`=1, `illegal`=1.
- PC=8'hFF NOP → PC wraps to 8'h00. Opcode 10000 → HALT, `illegal`=1, PC frozen for 10 cycles.
- Assert `rst` during the WB of ADD → no write in the next cycle. PC=0, flags 0, state FETCH.
